// File: rtl/st_timing_adapter_credit_fifo_if.sv
// st_timing_adapter_credit_fifo_if
// Avalon-ST beat bundle: valid/ready handshake plus data, packet markers
// and empty symbol count.
//   master : stream source (drives valid and payload, receives ready)
//   slave  : stream sink   (receives valid and payload, drives ready)
interface st_timing_adapter_credit_fifo_if #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned EMPTY_WIDTH = 2
);
  logic                   valid;
  logic                   ready;
  logic [DATA_WIDTH-1:0]  data;
  logic                   startofpacket;
  logic                   endofpacket;
  logic [EMPTY_WIDTH-1:0] empty;

  modport master (
    output valid, data, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  valid, data, startofpacket, endofpacket, empty,
    output ready
  );
endinterface

// File: rtl/st_timing_adapter_credit_fifo.sv
// st_timing_adapter_credit_fifo
// Absorbs an upstream Avalon-ST ready latency (IN_READY_LATENCY) into a
// credit-tracked FIFO and presents a ready-latency-0 source downstream.
// Ports:
//   clk, reset  : single rising-edge clock, synchronous active-high reset
//   in_st       : upstream sink side (in_ready granted IN_READY_LATENCY ahead)
//   out_st      : downstream source side, ready latency 0, head-of-FIFO payload
//   fill_level  : entries currently stored
//   overflow    : sticky dropped-beat flag
//   drop_count  : saturating dropped-beat counter
// Optional feature macro: ST_TIMING_ADAPTER_OVERFLOW_DETECT_EN enables the
// overflow flag and drop counter; otherwise both are tied to zero.
module st_timing_adapter_credit_fifo #(
  parameter int unsigned DATA_WIDTH       = 24,
  parameter int unsigned EMPTY_WIDTH      = 2,
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned IN_READY_LATENCY = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  st_timing_adapter_credit_fifo_if.slave  in_st,
  st_timing_adapter_credit_fifo_if.master out_st,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         overflow,
  output logic [7:0]                   drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam int unsigned CRD_W = FILL_W + 1;
  localparam int unsigned PAY_W = DATA_WIDTH + 2 + EMPTY_WIDTH;

  logic [PAY_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FILL_W-1:0] r_fill;

  logic [CRD_W-1:0]  w_inflight;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic [PAY_W-1:0]  w_in_payload;

  // Outstanding grants: in_ready values whose beats have not yet arrived.
  if (IN_READY_LATENCY > 0) begin : g_hist
    logic [IN_READY_LATENCY-1:0] r_hist;

    always_ff @(posedge clk) begin
      if (reset) r_hist <= '0;
      else       r_hist <= (r_hist << 1) | IN_READY_LATENCY'(w_in_ready);
    end

    always_comb begin
      w_inflight = '0;
      for (int i = 0; i < int'(IN_READY_LATENCY); i++) begin
        w_inflight = w_inflight + CRD_W'(r_hist[i]);
      end
    end
  end else begin : g_no_hist
    assign w_inflight = '0;
  end

  // Ready is a function of registered state only; pops raise it next cycle.
  assign w_in_ready  = !reset && ((CRD_W'(r_fill) + w_inflight) < CRD_W'(DEPTH));
  assign w_out_valid = (r_fill != '0);
  assign w_full      = (r_fill == FILL_W'(DEPTH));

  // With latency > 0 a beat was already granted, so valid alone pushes.
  assign w_push   = in_st.valid && ((IN_READY_LATENCY == 0) ? w_in_ready : 1'b1);
  assign w_pop    = w_out_valid && out_st.ready;
  assign w_accept = w_push && (!w_full || w_pop);

  assign w_in_payload = {in_st.data, in_st.startofpacket, in_st.endofpacket, in_st.empty};

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_fill <= r_fill + FILL_W'(1);
        2'b01:   r_fill <= r_fill - FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_accept && !reset) r_mem[r_wr_ptr] <= w_in_payload;
  end

  assign in_st.ready = w_in_ready;
  assign out_st.valid = w_out_valid;
  assign {out_st.data, out_st.startofpacket, out_st.endofpacket, out_st.empty} = r_mem[r_rd_ptr];
  assign fill_level = r_fill;

`ifdef ST_TIMING_ADAPTER_OVERFLOW_DETECT_EN
  logic       w_drop;
  logic       r_overflow;
  logic [7:0] r_drop_count;

  assign w_drop = w_push && w_full && !w_pop;

  // Sticky flag and saturating count of beats pushed into a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
`else
  assign overflow   = 1'b0;
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_st_timing_adapter_credit_fifo.sv
// tb_st_timing_adapter_credit_fifo
// Directed bench over three configurations:
//   u0: DEPTH 8, latency 0   u1: DEPTH 4, latency 1   u2: DEPTH 8, latency 2
module tb_st_timing_adapter_credit_fifo;

`ifdef ST_TIMING_ADAPTER_OVERFLOW_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [3:0] fl0, fl2;
  logic [2:0] fl1;
  logic       ovf0, ovf1, ovf2;
  logic [7:0] drp0, drp1, drp2;

  st_timing_adapter_credit_fifo_if #(.DATA_WIDTH(24), .EMPTY_WIDTH(2)) in0 ();
  st_timing_adapter_credit_fifo_if #(.DATA_WIDTH(24), .EMPTY_WIDTH(2)) out0 ();
  st_timing_adapter_credit_fifo_if #(.DATA_WIDTH(24), .EMPTY_WIDTH(2)) in1 ();
  st_timing_adapter_credit_fifo_if #(.DATA_WIDTH(24), .EMPTY_WIDTH(2)) out1 ();
  st_timing_adapter_credit_fifo_if #(.DATA_WIDTH(24), .EMPTY_WIDTH(2)) in2 ();
  st_timing_adapter_credit_fifo_if #(.DATA_WIDTH(24), .EMPTY_WIDTH(2)) out2 ();

  st_timing_adapter_credit_fifo #(.DATA_WIDTH(24), .EMPTY_WIDTH(2), .DEPTH(8), .IN_READY_LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .in_st(in0), .out_st(out0),
    .fill_level(fl0), .overflow(ovf0), .drop_count(drp0));

  st_timing_adapter_credit_fifo #(.DATA_WIDTH(24), .EMPTY_WIDTH(2), .DEPTH(4), .IN_READY_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .in_st(in1), .out_st(out1),
    .fill_level(fl1), .overflow(ovf1), .drop_count(drp1));

  st_timing_adapter_credit_fifo #(.DATA_WIDTH(24), .EMPTY_WIDTH(2), .DEPTH(8), .IN_READY_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .in_st(in2), .out_st(out2),
    .fill_level(fl2), .overflow(ovf2), .drop_count(drp2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] bh;
    int         n;
    int         tx;
    int         rx;
    logic       r;

    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    in0.valid = 1'b0; in0.data = '0; in0.startofpacket = 1'b0; in0.endofpacket = 1'b0; in0.empty = '0;
    in1.valid = 1'b0; in1.data = '0; in1.startofpacket = 1'b0; in1.endofpacket = 1'b0; in1.empty = '0;
    in2.valid = 1'b0; in2.data = '0; in2.startofpacket = 1'b0; in2.endofpacket = 1'b0; in2.empty = '0;
    out0.ready = 1'b0; out1.ready = 1'b0; out2.ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready0", 32'(in0.ready), 32'd0);
    chk("rst_in_ready1", 32'(in1.ready), 32'd0);
    chk("rst_in_ready2", 32'(in2.ready), 32'd0);
    chk("rst_out_valid0", 32'(out0.valid), 32'd0);
    chk("rst_fill0", 32'(fl0), 32'd0);
    chk("rst_fill2", 32'(fl2), 32'd0);
    chk("rst_ovf1", 32'(ovf1), 32'd0);
    chk("rst_drop1", 32'(drp1), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready0", 32'(in0.ready), 32'd1);
    chk("rel_in_ready1", 32'(in1.ready), 32'd1);
    chk("rel_in_ready2", 32'(in2.ready), 32'd1);

    // Back-to-back streaming, latency 0, sink always ready
    out0.ready = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("t1_valid", 32'(out0.valid), 32'd1);
        chk("t1_data", 32'(out0.data), 32'(k - 1));
        chk("t1_fill", 32'(fl0), 32'd1);
      end
      chk("t1_in_ready", 32'(in0.ready), 32'd1);
      in0.valid = (k < 20);
      in0.data  = 24'(k);
    end
    @(negedge clk);
    chk("t1_drained_valid", 32'(out0.valid), 32'd0);
    chk("t1_drained_fill", 32'(fl0), 32'd0);

    // Fill to capacity with valid held for 10 cycles
    out0.ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_in_ready", 32'(in0.ready), (i < 8) ? 32'd1 : 32'd0);
      in0.valid = 1'b1;
      in0.data  = 24'(100 + i);
    end
    @(negedge clk);
    in0.valid = 1'b0;
    chk("t2_full_fill", 32'(fl0), 32'd8);
    chk("t2_full_valid", 32'(out0.valid), 32'd1);
    out0.ready = 1'b1;
    for (int d = 0; d < 8; d++) begin
      if (d > 0) @(negedge clk);
      chk("t2_drain_data", 32'(out0.data), 32'(100 + d));
      chk("t2_drain_fill", 32'(fl0), 32'(8 - d));
      chk("t2_drain_in_ready", 32'(in0.ready), (d == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    out0.ready = 1'b0;
    chk("t2_empty_fill", 32'(fl0), 32'd0);
    chk("t2_empty_valid", 32'(out0.valid), 32'd0);

    // Latency-2 source that only sends beats on grants
    bh = 2'b00;
    n  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t3_in_ready", 32'(in2.ready), (c < 8) ? 32'd1 : 32'd0);
      in2.valid = bh[1];
      in2.data  = 24'(32'h300 + n);
      if (bh[1]) n++;
      bh = {bh[0], in2.ready};
    end
    @(negedge clk);
    in2.valid = 1'b0;
    chk("t3_fill", 32'(fl2), 32'd8);
    chk("t3_ovf", 32'(ovf2), 32'd0);
    chk("t3_drop", 32'(drp2), 32'd0);
    out2.ready = 1'b1;
    for (int d = 0; d < 8; d++) begin
      if (d > 0) @(negedge clk);
      chk("t3_drain_data", 32'(out2.data), 32'h300 + 32'(d));
    end
    @(negedge clk);
    out2.ready = 1'b0;
    chk("t3_empty_fill", 32'(fl2), 32'd0);

    // Latency-1, DEPTH 4: fill, then push into full FIFO with no pop
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in1.valid = 1'b1;
      in1.data  = 24'(32'h40 + i);
    end
    @(negedge clk);
    in1.data = 24'hEE;
    @(negedge clk);
    in1.valid = 1'b0;
    chk("t4_fill", 32'(fl1), 32'd4);
    chk("t4_head", 32'(out1.data), 32'h40);
    chk("t4_ovf", 32'(ovf1), 32'(OVF_EN));
    chk("t4_drop1", 32'(drp1), OVF_EN ? 32'd1 : 32'd0);
    for (int i = 0; i < 299; i++) begin
      @(negedge clk);
      in1.valid = 1'b1;
      in1.data  = 24'hDD;
    end
    @(negedge clk);
    in1.valid = 1'b0;
    chk("t4_drop_sat", 32'(drp1), OVF_EN ? 32'd255 : 32'd0);
    out1.ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (d > 0) @(negedge clk);
      chk("t4_drain_data", 32'(out1.data), 32'h40 + 32'(d));
    end
    @(negedge clk);
    out1.ready = 1'b0;
    chk("t4_empty_valid", 32'(out1.valid), 32'd0);
    chk("t4_ovf_sticky", 32'(ovf1), 32'(OVF_EN));

    // Packet markers through FIFO with random sink backpressure
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 200 && rx < 5; cyc++) begin
      @(negedge clk);
      r = 1'($urandom_range(0, 1));
      out0.ready = r;
      if (out0.valid && r) begin
        chk("t5_data", 32'(out0.data), 32'h500 + 32'(rx));
        chk("t5_sop", 32'(out0.startofpacket), (rx == 0) ? 32'd1 : 32'd0);
        chk("t5_eop", 32'(out0.endofpacket), (rx == 4) ? 32'd1 : 32'd0);
        chk("t5_empty", 32'(out0.empty), (rx == 4) ? 32'd2 : 32'd0);
        rx++;
      end
      if (tx < 5) begin
        in0.valid         = 1'b1;
        in0.data          = 24'(32'h500 + tx);
        in0.startofpacket = (tx == 0);
        in0.endofpacket   = (tx == 4);
        in0.empty         = (tx == 4) ? 2'd2 : 2'd0;
        if (in0.ready) tx++;
      end else begin
        in0.valid = 1'b0;
      end
    end
    chk("t5_beats_received", 32'(rx), 32'd5);
    @(negedge clk);
    out0.ready = 1'b0;
    in0.valid = 1'b0; in0.startofpacket = 1'b0; in0.endofpacket = 1'b0; in0.empty = '0;
    chk("t5_empty_fill", 32'(fl0), 32'd0);

    // Reset mid-operation with five entries stored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in0.valid = 1'b1;
      in0.data  = 24'(32'h600 + i);
    end
    @(negedge clk);
    chk("t6_fill5", 32'(fl0), 32'd5);
    in0.data = 24'hBAD;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 32'(out0.valid), 32'd0);
    chk("t6_rst_fill", 32'(fl0), 32'd0);
    chk("t6_rst_in_ready", 32'(in0.ready), 32'd0);
    reset = 1'b0;
    in0.valid = 1'b1;
    in0.data  = 24'hABCDEF;
    #1;
    chk("t6_rel_in_ready", 32'(in0.ready), 32'd1);
    @(negedge clk);
    in0.valid = 1'b0;
    chk("t6_new_valid", 32'(out0.valid), 32'd1);
    chk("t6_new_data", 32'(out0.data), 32'hABCDEF);
    chk("t6_new_fill", 32'(fl0), 32'd1);
    out0.ready = 1'b1;
    @(negedge clk);
    out0.ready = 1'b0;
    chk("t6_final_fill", 32'(fl0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
